// File: rtl/mem_access_if.sv
// Word-organised data-memory bus between the memory-stage controller and the RAM.
// The controller drives the request side; the memory answers with ack/rdata.
interface mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-stage access controller: turns an EX/MEM load/store into a req/ack
// transaction on a big-endian word memory and stalls the pipeline until it ends.
module mem_access #(
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inValid,
  input  logic                memRd,
  input  logic                memWrt,
  input  logic                byteMode,
  input  logic [15:0]         ALUResult,
  input  logic [15:0]         op1Val,
  mem_access_if.master        mem,
  output logic [15:0]         memRead,
  output logic                stall,
  output logic                memErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        req_q;
  logic        we_q;
  logic [14:0] addr_q;
  logic [1:0]  be_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        err_q;

  logic        access;
  logic        misalign;
  logic [1:0]  be_d;
  logic [15:0] wdata_d;
  logic [15:0] load_d;
  logic [7:0]  cnt_d;

  // Byte lane 0 (address bit 0 clear) is the high byte of the word.
  function automatic logic [1:0] lane_be(input logic bm, input logic a0);
    if (!bm)    return 2'b11;
    else if (a0) return 2'b01;
    else         return 2'b10;
  endfunction

  function automatic logic [15:0] load_extract(input logic [15:0] w, input logic [1:0] be);
    case (be)
      2'b10:   return {{8{w[15]}}, w[15:8]};
      2'b01:   return {{8{w[7]}}, w[7:0]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    access   = inValid & (memRd | memWrt);
    misalign = ~byteMode & ALUResult[0];
    be_d     = lane_be(byteMode, ALUResult[0]);
    wdata_d  = byteMode ? {op1Val[7:0], op1Val[7:0]} : op1Val;
    load_d   = load_extract(mem.mem_rdata, be_q);
    cnt_d    = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access) begin
            if (misalign) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              // A set memWrt wins over memRd: the access becomes a store.
              req_q   <= 1'b1;
              we_q    <= memWrt;
              addr_q  <= ALUResult[15:1];
              be_q    <= be_d;
              wdata_q <= wdata_d;
              cnt_q   <= '0;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem.mem_ack) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) rdata_q <= load_d;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == TMO) begin
              req_q   <= 1'b0;
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Gated by rst so an in-flight access releases the pipeline during reset.
  assign stall = rst & (((state_q == IDLE) & access & ~misalign) | (state_q == BUSY));

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
  assign memRead       = rdata_q;
  assign memErr        = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, misalignment, timeout and reset mid-access.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        memRd;
  logic        memWrt;
  logic        byteMode;
  logic [15:0] ALUResult;
  logic [15:0] op1Val;
  logic [15:0] memRead;
  logic        stall;
  logic        memErr;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .inValid   (inValid),
    .memRd     (memRd),
    .memWrt    (memWrt),
    .byteMode  (byteMode),
    .ALUResult (ALUResult),
    .op1Val    (op1Val),
    .mem       (bus.master),
    .memRead   (memRead),
    .stall     (stall),
    .memErr    (memErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Observations from one access
  int          o_stalls;
  int          o_reqs;
  logic        o_err;
  logic        o_we;
  logic [1:0]  o_be;
  logic [14:0] o_addr;
  logic [15:0] o_wdata;
  logic [15:0] o_rd;
  logic        o_unstable;

  task automatic do_access(input logic rd, input logic wr, input logic bm,
                           input logic [15:0] addr, input logic [15:0] wd,
                           input int waits, input logic [15:0] rdata);
    int  busy_n;
    bit  seen;
    bit  ended;
    busy_n = 0; seen = 0; ended = 0;
    o_stalls = 0; o_reqs = 0; o_err = 0; o_unstable = 0;
    o_we = 0; o_be = 0; o_addr = 0; o_wdata = 0;
    @(posedge clk); #1;
    inValid = 1'b1; memRd = rd; memWrt = wr; byteMode = bm;
    ALUResult = addr; op1Val = wd; bus.mem_rdata = rdata;
    for (int c = 0; c < 40 && !ended; c++) begin
      @(negedge clk);
      if (stall)  o_stalls++;
      if (memErr) o_err = 1'b1;
      if (bus.mem_req) begin
        o_reqs++;
        if (!seen) begin
          seen = 1; o_we = bus.mem_we; o_be = bus.mem_be;
          o_addr = bus.mem_addr; o_wdata = bus.mem_wdata;
        end else if (bus.mem_we !== o_we || bus.mem_be !== o_be ||
                     bus.mem_addr !== o_addr || bus.mem_wdata !== o_wdata) begin
          o_unstable = 1'b1;
        end
        bus.mem_ack = (busy_n == waits);
        busy_n++;
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (!stall) begin
        ended = 1;
        o_rd = memRead;
      end
    end
    if (!ended) check("access_bound", 32'd0, 32'd1);
    @(posedge clk); #1;
    inValid = 1'b0; memRd = 1'b0; memWrt = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    if (memErr) o_err = 1'b1;
    if (!ended) o_rd = memRead;
  endtask

  initial begin
    rst = 1'b0; inValid = 1'b0; memRd = 1'b0; memWrt = 1'b0; byteMode = 1'b0;
    ALUResult = '0; op1Val = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #12;
    check("rst_req",   {31'd0, bus.mem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_err",   {31'd0, memErr}, 32'd0);
    check("rst_rd",    {16'd0, memRead}, 32'd0);
    check("rst_addr",  {17'd0, bus.mem_addr}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Word load, ack in first BUSY cycle
    do_access(1, 0, 0, 16'h0040, 16'h0000, 0, 16'hBEEF);
    check("wl_addr",   {17'd0, o_addr}, 32'h20);
    check("wl_be",     {30'd0, o_be}, 32'h3);
    check("wl_we",     {31'd0, o_we}, 32'd0);
    check("wl_stall",  o_stalls, 32'd2);
    check("wl_rd",     {16'd0, o_rd}, 32'hBEEF);
    check("wl_err",    {31'd0, o_err}, 32'd0);

    // Byte loads from 16'h807F
    do_access(1, 0, 1, 16'h0041, 16'h0000, 0, 16'h807F);
    check("bl1_be",    {30'd0, o_be}, 32'h1);
    check("bl1_rd",    {16'd0, o_rd}, 32'h007F);
    do_access(1, 0, 1, 16'h0040, 16'h0000, 0, 16'h807F);
    check("bl0_be",    {30'd0, o_be}, 32'h2);
    check("bl0_rd",    {16'd0, o_rd}, 32'hFF80);

    // Byte store after 3 wait cycles
    do_access(0, 1, 1, 16'h0011, 16'h12AB, 3, 16'h5555);
    check("bs_we",     {31'd0, o_we}, 32'd1);
    check("bs_be",     {30'd0, o_be}, 32'h1);
    check("bs_addr",   {17'd0, o_addr}, 32'h8);
    check("bs_wdata",  {16'd0, o_wdata}, 32'hABAB);
    check("bs_stall",  o_stalls, 32'd5);
    check("bs_stable", {31'd0, o_unstable}, 32'd0);
    check("bs_rd",     {16'd0, o_rd}, 32'hFF80);

    // memRd and memWrt together: word store
    do_access(1, 1, 0, 16'h0102, 16'hC3A5, 1, 16'h1111);
    check("ws_we",     {31'd0, o_we}, 32'd1);
    check("ws_wdata",  {16'd0, o_wdata}, 32'hC3A5);
    check("ws_err",    {31'd0, o_err}, 32'd0);
    check("ws_rd",     {16'd0, o_rd}, 32'hFF80);

    // Misaligned word load
    do_access(1, 0, 0, 16'h0003, 16'h0000, 0, 16'h2222);
    check("ma_req",    o_reqs, 32'd0);
    check("ma_stall",  o_stalls, 32'd0);
    check("ma_err",    {31'd0, o_err}, 32'd1);
    check("ma_rd",     {16'd0, memRead}, 32'd0);

    // Timeout: reload a nonzero value first
    do_access(1, 0, 0, 16'h0200, 16'h0000, 0, 16'h1234);
    check("pre_rd",    {16'd0, o_rd}, 32'h1234);
    do_access(1, 0, 0, 16'h0300, 16'h0000, 1000, 16'h9999);
    check("to_req",    o_reqs, 32'd15);
    check("to_stall",  o_stalls, 32'd16);
    check("to_err",    {31'd0, o_err}, 32'd1);
    check("to_rd",     {16'd0, o_rd}, 32'd0);

    // Reset while BUSY
    @(posedge clk); #1;
    inValid = 1'b1; memRd = 1'b1; memWrt = 1'b0; byteMode = 1'b0; ALUResult = 16'h0100;
    @(negedge clk);
    @(negedge clk);
    check("rb_req_up", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("rb_req",    {31'd0, bus.mem_req}, 32'd0);
    check("rb_stall",  {31'd0, stall}, 32'd0);
    check("rb_err",    {31'd0, memErr}, 32'd0);
    @(posedge clk); #1;
    inValid = 1'b0; memRd = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("rb_err2",   {31'd0, memErr}, 32'd0);
    do_access(1, 0, 0, 16'h0400, 16'h0000, 0, 16'h0F0F);
    check("rb_rd",     {16'd0, o_rd}, 32'h0F0F);
    check("rb_stalls", o_stalls, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage access controller between the EX/MEM pipeline register and `mem_wb`. It takes a load/store from EX/MEM and drives a word-organised data memory over a req/ack handshake. It stalls the upstream pipeline until the access completes or times out, and produces the registered `memRead` value that `mem_wb` captures.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum BUSY cycles without `mem_ack` before the access is aborted (1..255).

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `inValid` input 1: EX/MEM holds a valid instruction.
- `memRd` input 1: load.
- `memWrt` input 1: store.
- `byteMode` input 1: byte access (1) or word access (0).
- `ALUResult` input 16: byte address.
- `op1Val` input 16: store data.
- `mem_ack` input 1: memory completes the current request.
- `mem_rdata` input 16: memory read word, valid with `mem_ack`.
- `mem_req` output 1: request, registered.
- `mem_we` output 1: write enable, registered.
- `mem_addr` output 15: word address `ALUResult[15:1]`, registered.
- `mem_be` output 2: byte enables, registered. Bit 1 selects `[15:8]`, bit 0 selects `[7:0]`.
- `mem_wdata` output 16: write data, registered.
- `memRead` output 16: load result to `mem_wb`, registered.
- `stall` output 1: holds EX/MEM and earlier stages, combinational.
- `memErr` output 1: one-cycle error pulse, registered.

## Operation
- States are IDLE, BUSY and DONE.
- The memory is big-endian. Byte address bit 0 = 0 selects `[15:8]`; bit 0 = 1 selects `[7:0]`.
- An access is `inValid & (memRd | memWrt)`. When `memRd` and `memWrt` are both set, the access is a write; no error is raised.
- A misaligned access is a word access with `ALUResult[0]=1`.
- IDLE, aligned access:
  - `stall=1`.
  - Next edge: load `mem_req=1`, `mem_we`, `mem_addr` and `mem_be` (11 for a word, 10 or 01 for a byte), clear the timeout counter, go to BUSY.
  - `mem_wdata` is `op1Val` for a word store and `{op1Val[7:0],op1Val[7:0]}` for a byte store.
- IDLE, misaligned access:
  - `stall=0`; no request is issued.
  - Next edge: `memErr=1` for one cycle, `memRead` is cleared to 0, state stays IDLE.
- IDLE, no access: `stall=0`; `memRead` and `mem_*` outputs hold.
- BUSY:
  - `stall=1`.
  - On `mem_ack`:
    - `mem_req=0`, go to DONE.
    - Load, word: `memRead=mem_rdata`.
    - Load, byte: `memRead` is the sign-extended selected byte.
    - Store: `memRead` unchanged.
  - Without `mem_ack`: the counter increments. When it reaches `TIMEOUT`: `mem_req=0`, `memErr=1` for one cycle, `memRead=0`, go to DONE.
- DONE:
  - `stall=0`, so the instruction leaves EX/MEM at the end of this cycle.
  - An access still presented this cycle is not restarted.
  - Next edge: go to IDLE.
- `mem_ack` outside BUSY is ignored.
- `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are stable for the whole BUSY period.

## Timing
- Reset (async, `rst=0`): state IDLE; `mem_req`, `mem_we`, `memErr` and `stall` = 0; `mem_addr`, `mem_be`, `mem_wdata` and `memRead` = 0; counter = 0.
- A reset during BUSY drops `mem_req` immediately; the access is abandoned and no `memErr` is raised.
- Best case with ack in the first BUSY cycle:
  - Cycle N (IDLE, access seen): stall=1.
  - N+1 (BUSY, `mem_req`=1, ack arrives): stall=1.
  - N+2 (DONE): stall=0, `memRead` valid.
  - Total: 2 stall cycles.
- Every additional wait cycle adds one stall cycle.
- Timeout: with no ack, BUSY lasts exactly `TIMEOUT` cycles. DONE follows with `memErr=1` during the DONE cycle.
- `memErr` is high in the DONE cycle for a timeout, and in the cycle after IDLE detection for a misaligned access.
- `memRead` changes only on the DONE-entry edge, the misaligned-error edge, or reset.
- Back-to-back accesses: the minimum spacing is 3 cycles (IDLE → BUSY → DONE → IDLE).

## Test plan
- Word load at `ALUResult=16'h0040`, `mem_rdata=16'hBEEF`, ack in the first BUSY cycle:
  - `mem_addr=15'h0020`, `mem_be=11`, `mem_we=0`.
  - `stall` high for exactly 2 cycles.
  - `memRead=16'hBEEF` in DONE.
- Byte loads from `mem_rdata=16'h80_7F`:
  - At `ALUResult=16'h0041`: `mem_be=01`, `memRead=16'h007F`.
  - At `16'h0040`: `mem_be=10`, `memRead=16'hFF80`.
- Byte store with `op1Val=16'h12AB` at `16'h0011`, ack after 3 wait cycles:
  - `mem_we=1`, `mem_be=01`, `mem_wdata=16'hABAB`.
  - `stall` high for 5 cycles.
  - `memRead` unchanged.
- Word load at `16'h0003`:
  - No `mem_req`, `stall=0`.
  - `memErr` pulses 1 cycle, `memRead=0`.
- Load with `mem_ack` never asserted and `TIMEOUT=15`:
  - `mem_req` high for exactly 15 cycles.
  - `memErr` pulse, `memRead=0`, `stall` released in DONE.
- Reset mid-BUSY:
  - `rst` low for 1 cycle while `mem_req=1` drops `mem_req` and `stall` immediately, with no `memErr`.
  - After release, a new word load completes normally.
